data_memory: RTL and testbench
==============================

# data_memory

Word-addressed data memory (DM) for the single-cycle MIPS datapath. Sits after the ALU in the MEM stage: the ALU result is the byte address, rt supplies write data, and the read word feeds the register-file write-back mux. It has a synchronous write and an asynchronous (combinational) read. Its contents clear to zero on reset.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-index width; capacity is 2^ADDR_WIDTH 32-bit words (default 1024 words = 4 KiB).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted, clears the whole array immediately, independent of clk).
- WE  input  1  write enable, active-high, sampled at rising clk.
- WD  input  32  write data.
- addr  input  32  byte address; word index = addr[ADDR_WIDTH+1:2].
- RD  output  32  read data, combinational from addr and current array contents.

## Operation
- Storage: array of 2^ADDR_WIDTH 32-bit words, index i covers byte addresses 4i..4i+3.
- Address decode:
  - addr[1:0] are ignored; all accesses are word-aligned.
  - in-range when addr[31:ADDR_WIDTH+2] == 0.
- Write: on rising clk, with reset = 1, WE = 1 and addr in range, mem[index] <= WD.
- Write suppression: WE = 0 or an out-of-range addr leaves the array unchanged (no wrap-around to low addresses).
- Read: RD = mem[index] when addr is in range, else 32'h0000_0000. No read enable.
- Reset: while reset = 0, every word reads 0, RD = 0 and writes are blocked. Contents stay 0 after release until written.
- Power-up: array is initialized to 0 (simulation initial state equals the reset state).
- No byte/halfword access; only lw/sw word semantics.

## Timing
- Write latency: 1 clock. The value written at rising edge N is visible on RD immediately after edge N (same delta-settled time) when addr still selects that word.
- Read latency: 0 cycles (combinational). RD follows addr changes and post-edge array updates without waiting for a clock.
- Reset assertion is asynchronous: RD goes to 0 without a clock edge. Deassertion takes effect at the next rising edge for writes.
- Simultaneous reset = 0 and WE = 1 at an edge: reset wins, no write.
- Reading the address being written in the same cycle:
  - before the edge, RD shows the old word;
  - after the edge, RD shows WD.
- Back-to-back writes to different or identical addresses on consecutive edges are all honored; the last write to an address wins.

## Test plan
- Reset: hold reset = 0 for 10 ns, WE = 1, WD = 32'hFFFF_FFFF, addr = 4 over a clk edge -> RD = 0; after releasing reset with WE = 0, reading addr 4 -> RD = 0.
- Basic write/read: reset = 1, WE = 1, WD = 100, addr = 32'h4, clk period 10 ns -> after the next rising edge RD = 100. Then WD = 200, addr = 32'hC -> after the next edge RD = 200. Then WE = 0, addr = 4 -> RD = 100.
- Write disable: WE = 0, WD = 55, addr = 8 over several edges -> RD stays 0.
- Alignment: write 32'hDEAD_BEEF to addr 32'h10; read addr 32'h13 -> RD = 32'hDEAD_BEEF.
- Out of range: WE = 1, addr = 32'h0000_1000 (ADDR_WIDTH = 10), WD = 7 -> RD = 0, and addr 0 still reads its previous value (no aliasing).
- Async reset mid-operation: after filling words 0..3, drive reset = 0 between clock edges -> RD = 0 immediately. After release, all four words read 0.

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed data memory for the MEM stage of the single-cycle MIPS datapath.
// Synchronous write, combinational read; the whole array clears on asynchronous reset.
module data_memory #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        WE,
   input  logic [31:0] WD,
   input  logic [31:0] addr,
   output logic [31:0] RD
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 32'(1) << ADDR_WIDTH;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic                  in_range;
   logic                  unused_byte_offset;

   // Byte offset is ignored; any set bit above the word index is out of range.
   assign idx                = addr[ADDR_WIDTH+1:2];
   assign in_range           = (addr[DATA_W-1:ADDR_WIDTH+2] == '0);
   assign unused_byte_offset = ^addr[1:0];

   // Storage: reset clears every word, out-of-range writes are dropped rather than wrapped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (WE && in_range) begin
         mem[idx] <= WD;
      end
   end

   // Combinational read port.
   always_comb begin
      RD = '0;
      if (reset && in_range) begin
         RD = mem[idx];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases followed by randomized traffic
// compared against an array model of the memory.
module tb_data_memory;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned BYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] wd;
   logic [31:0] addr;
   logic [31:0] rd;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   data_memory #(.ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .WE    (we),
      .WD    (wd),
      .addr  (addr),
      .RD    (rd)
   );

   function automatic bit in_range(input logic [31:0] a);
      return a < 32'(BYTES);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!reset || !in_range(a)) return 32'h0;
      return model[AW'(a / 4)];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One clock with given inputs; checks the old word before the edge and the new one after.
   task automatic clock_op(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input string tag);
      addr = a;
      wd   = d;
      we   = w;
      #1;
      check({tag, "_pre"}, rd, model_read(a));
      @(posedge clk);
      if (reset && w && in_range(a)) model[AW'(a / 4)] = d;
      #1;
      check({tag, "_post"}, rd, model_read(a));
      @(negedge clk);
   endtask

   task automatic read_at(input logic [31:0] a, input logic [31:0] exp, input string tag);
      we   = 1'b0;
      addr = a;
      #1;
      check(tag, rd, exp);
   endtask

   // Asynchronous reset pulse between edges with a write pending; reset must win.
   task automatic reset_pulse(input logic [31:0] a, input string tag);
      #2;
      addr  = a;
      wd    = $urandom;
      we    = 1'b1;
      reset = 1'b0;
      #1;
      check(tag, rd, 32'h0);
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      we    = 1'b0;
      #1;
      check({tag, "_rel"}, rd, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int unsigned r;

      model_clear();
      reset = 1'b0;
      we    = 1'b1;
      wd    = 32'hFFFF_FFFF;
      addr  = 32'h4;

      // Reset held across an edge with a write attempt.
      @(posedge clk);
      #1;
      check("reset_hold", rd, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      read_at(32'h4, 32'h0, "reset_release");

      // Basic write/read.
      clock_op(32'h4, 32'd100, 1'b1, "wr4");
      check("wr4_val", rd, 32'd100);
      clock_op(32'hC, 32'd200, 1'b1, "wrC");
      check("wrC_val", rd, 32'd200);
      read_at(32'h4, 32'd100, "rd4");

      // Write disabled.
      repeat (3) clock_op(32'h8, 32'd55, 1'b0, "wdis");
      read_at(32'h8, 32'h0, "wdis_val");

      // Byte offset ignored.
      clock_op(32'h10, 32'hDEAD_BEEF, 1'b1, "align_wr");
      read_at(32'h13, 32'hDEAD_BEEF, "align_rd13");
      read_at(32'h11, 32'hDEAD_BEEF, "align_rd11");

      // Out of range: no write, reads zero, no aliasing onto word 0.
      clock_op(32'h0, 32'h1234_5678, 1'b1, "wr0");
      clock_op(32'h0000_1000, 32'd7, 1'b1, "oor_wr");
      read_at(32'h0000_1000, 32'h0, "oor_rd");
      read_at(32'h0, 32'h1234_5678, "oor_alias0");
      clock_op(32'h8000_0004, 32'd9, 1'b1, "oor_hi");
      read_at(32'h4, 32'd100, "oor_alias4");

      // Back-to-back writes to the same word: last wins.
      clock_op(32'h20, 32'hAAAA_0001, 1'b1, "b2b_a");
      clock_op(32'h20, 32'hAAAA_0002, 1'b1, "b2b_b");
      read_at(32'h20, 32'hAAAA_0002, "b2b_last");

      // Fill words 0..3, then asynchronous reset between edges.
      for (int i = 0; i < 4; i++) clock_op(32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, "fill");
      read_at(32'hC, 32'hC0DE_0003, "fill_w3");
      reset_pulse(32'h4, "async_rst");
      for (int i = 0; i < 4; i++) read_at(32'(i * 4), 32'h0, "post_rst");

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         d = $urandom;
         if (r < 30) a = {20'h0, 4'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
         else        a = {20'h0, 12'($urandom)};
         if (r < 55) begin
            clock_op(a, d, 1'b1, "rnd_wr");
         end else if (r < 70) begin
            clock_op(a, d, 1'b0, "rnd_nowr");
         end else if (r < 85) begin
            read_at(a, model_read(a), "rnd_rd");
         end else if (r < 97) begin
            a = $urandom;
            if (in_range(a)) a = a | 32'h0000_1000;
            clock_op(a, d, 1'b1, "rnd_oor");
         end else begin
            reset_pulse(a, "rnd_rst");
            @(negedge clk);
         end
      end

      // Final sweep of the whole array.
      for (int i = 0; i < int'(DEPTH); i++) read_at(32'(i * 4), model[i], "sweep");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
